fetch_ctrl: RTL and testbench

- Sequences instruction fetch from the synchronous-read instruction memory (one-cycle read latency) into a 2-entry instruction buffer.
- Presents instructions to decode through a valid/ready handshake.
- Handles start/halt control and branch/jump redirects from execute, including squashing wrong-path reads already in flight.
- Sits between the instruction memory and the decode stage and replaces the free-running PC counter.

---
 rtl/fetch_ctrl.sv | 151 +++++++++++++++
 tb/tb_fetch_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: sequences reads from a one-cycle-latency instruction memory
// into a 2-entry instruction buffer and hands instructions to decode over a
// valid/ready handshake. Handles start/halt and execute redirects.
// A response arriving while the buffer is empty is forwarded straight to
// the head, so the first instruction shows up two cycles after start/redirect.
module fetch_ctrl #(
    parameter int INST_WIDTH = 32,
    parameter int MEM_SIZE   = 16,
    parameter int RESET_PC   = 0,
    parameter int BUF_DEPTH  = 2,
    localparam int AW        = $clog2(MEM_SIZE)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  halt_req,
    input  logic                  redirect_valid,
    input  logic [AW-1:0]         redirect_pc,
    output logic                  imem_rd_en,
    output logic [AW-1:0]         imem_addr,
    input  logic [INST_WIDTH-1:0] imem_data,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [INST_WIDTH-1:0] inst,
    output logic [AW-1:0]         inst_pc,
    output logic                  busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_DRAIN  = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    // Next sequential fetch address, wrapping at the end of memory.
    function automatic logic [AW-1:0] pc_inc(input logic [AW-1:0] cur);
        if (cur == AW'(MEM_SIZE - 1)) return '0;
        return cur + AW'(1);
    endfunction

    state_t                  state, state_nxt;
    logic [AW-1:0]           pc;

    // Read issue stage (p1): one read outstanding at most, with its address tag.
    logic                    vld_p1;
    logic                    squash_p1;
    logic [AW-1:0]           tag_pc_p1;

    // Instruction buffer storage and pointers.
    logic [INST_WIDTH-1:0]   buf_inst [0:1];
    logic [AW-1:0]           buf_pc   [0:1];
    logic                    rd_ptr, wr_ptr;
    logic [1:0]              count;

    logic                    resp_vld;
    logic                    buf_nonempty;
    logic                    deq;
    logic                    pop;
    logic                    wr_en;
    logic                    flush;
    logic [2:0]              occ_after;

    assign resp_vld     = vld_p1 && !squash_p1;
    assign buf_nonempty = (count != 2'd0);
    assign inst_valid   = buf_nonempty || resp_vld;
    assign deq          = inst_valid && inst_ready;
    assign pop          = deq && buf_nonempty;
    // A response consumed directly through the bypass never lands in the buffer.
    assign wr_en        = resp_vld && !(deq && !buf_nonempty);
    assign flush        = redirect_valid && (state != S_IDLE);

    assign inst    = !inst_valid  ? '0 :
                     buf_nonempty ? buf_inst[rd_ptr] : imem_data;
    assign inst_pc = !inst_valid  ? '0 :
                     buf_nonempty ? buf_pc[rd_ptr]   : tag_pc_p1;

    // Entries held plus the one in flight, after this cycle's dequeue.
    assign occ_after  = 3'(count) + 3'(vld_p1) - 3'(deq);
    assign imem_rd_en = (state == S_RUN) && !halt_req && !redirect_valid &&
                        (occ_after < 3'(BUF_DEPTH));
    assign imem_addr  = pc;
    assign busy       = (state == S_RUN) || (state == S_DRAIN);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic for start/halt sequencing.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_RUN;
            S_RUN:    if (halt_req) state_nxt = S_DRAIN;
            S_DRAIN:  if (!vld_p1) state_nxt = S_HALTED;
            S_HALTED: if (start) state_nxt = halt_req ? S_DRAIN : S_RUN;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // PC and in-flight read tracking; a redirect reloads pc and kills the response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc        <= AW'(RESET_PC);
            vld_p1    <= 1'b0;
            squash_p1 <= 1'b0;
        end else begin
            vld_p1    <= imem_rd_en;
            squash_p1 <= flush && vld_p1;
            if (flush)           pc <= redirect_pc;
            else if (imem_rd_en) pc <= pc_inc(pc);
        end
    end

    // Address tag travels with the read into the response stage.
    always_ff @(posedge clk) begin
        if (imem_rd_en) tag_pc_p1 <= pc;
    end

    // Buffer occupancy and pointers; flush empties the buffer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (wr_en) wr_ptr <= ~wr_ptr;
            if (pop)   rd_ptr <= ~rd_ptr;
            count <= count + 2'(wr_en) - 2'(pop);
        end
    end

    // Buffer storage: capture the memory response at the tail.
    always_ff @(posedge clk) begin
        if (wr_en && !flush) begin
            buf_inst[wr_ptr] <= imem_data;
            buf_pc[wr_ptr]   <= tag_pc_p1;
        end
    end

    // The issue rule must never let a response reach a full buffer.
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(wr_en && !flush && !pop && count == 2'(BUF_DEPTH)));

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed and randomized stimulus for fetch_ctrl, checked
// every cycle against a queue-based reference model of the fetch pipeline.
module tb_fetch_ctrl;

    localparam int INST_WIDTH = 32;
    localparam int MEM_SIZE   = 16;
    localparam int AW         = 4;
    localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_HALTED = 3;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  start;
    logic                  halt_req;
    logic                  redirect_valid;
    logic [AW-1:0]         redirect_pc;
    logic                  imem_rd_en;
    logic [AW-1:0]         imem_addr;
    logic [INST_WIDTH-1:0] imem_data;
    logic                  inst_valid;
    logic                  inst_ready;
    logic [INST_WIDTH-1:0] inst;
    logic [AW-1:0]         inst_pc;
    logic                  busy;

    fetch_ctrl #(
        .INST_WIDTH (INST_WIDTH),
        .MEM_SIZE   (MEM_SIZE),
        .RESET_PC   (0),
        .BUF_DEPTH  (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .halt_req       (halt_req),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_rd_en     (imem_rd_en),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // Synchronous-read instruction memory, one cycle latency.
    logic [INST_WIDTH-1:0] mem [0:MEM_SIZE-1];
    always @(posedge clk) begin
        if (imem_rd_en) imem_data <= mem[imem_addr];
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: pipeline content as queues of word addresses.
    int m_state;
    int m_pc;
    int m_buf[$];
    int m_pend;
    bit m_pend_v;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state  = M_IDLE;
        m_pc     = 0;
        m_buf.delete();
        m_pend_v = 1'b0;
        m_pend   = 0;
    endtask

    // One clock cycle: drive inputs, compare against the model, advance the model.
    task automatic step(input bit st, input bit hr, input bit rv, input int rpc, input bit rdy);
        int  vis[$];
        bit  ev, dq, er, infl;
        @(negedge clk);
        start          = st;
        halt_req       = hr;
        redirect_valid = rv;
        redirect_pc    = AW'(rpc);
        inst_ready     = rdy;
        #1;
        vis = m_buf;
        if (m_pend_v) vis.push_back(m_pend);
        ev = (vis.size() > 0);
        dq = ev && rdy;
        er = (m_state == M_RUN) && !hr && !rv && ((vis.size() - int'(dq)) < 2);
        check("inst_valid", inst_valid, ev);
        check("imem_rd_en", imem_rd_en, er);
        check("busy", busy, (m_state == M_RUN) || (m_state == M_DRAIN));
        if (er) check("imem_addr", imem_addr, m_pc);
        if (ev) begin
            check("inst_pc", inst_pc, vis[0]);
            check("inst", inst, mem[vis[0]]);
        end
        if (dq) void'(vis.pop_front());
        m_buf = vis;
        infl  = m_pend_v;
        if (rv && m_state != M_IDLE) begin
            m_buf.delete();
            m_pc     = rpc;
            m_pend_v = 1'b0;
        end else begin
            m_pend_v = er;
            m_pend   = m_pc;
            if (er) m_pc = (m_pc + 1) % MEM_SIZE;
        end
        case (m_state)
            M_IDLE:   if (st) m_state = M_RUN;
            M_RUN:    if (hr) m_state = M_DRAIN;
            M_DRAIN:  if (!infl) m_state = M_HALTED;
            default:  if (st) m_state = hr ? M_DRAIN : M_RUN;
        endcase
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        start = 0; halt_req = 0; redirect_valid = 0; redirect_pc = '0; inst_ready = 0;
        repeat (2) @(negedge clk);
        check("rst_inst_valid", inst_valid, 1'b0);
        check("rst_imem_rd_en", imem_rd_en, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_inst", inst, '0);
        check("rst_inst_pc", inst_pc, '0);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        for (int k = 0; k < MEM_SIZE; k++) mem[k] = 32'h1000 + k;
        reset = 1'b1;
        start = 0; halt_req = 0; redirect_valid = 0; redirect_pc = '0; inst_ready = 0;
        model_reset();
        apply_reset();

        // Idle until start, then streaming with decode always ready.
        repeat (2) step(0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        repeat (4) step(0, 0, 0, 0, 1);
        // Redirect to 9 with a read in flight.
        step(0, 0, 1, 9, 1);
        repeat (5) step(0, 0, 0, 0, 1);
        // Backpressure for 5 cycles, then release.
        repeat (5) step(0, 0, 0, 0, 0);
        repeat (6) step(0, 0, 0, 0, 1);
        // Wrap from the top of memory.
        step(0, 0, 1, 14, 1);
        repeat (6) step(0, 0, 0, 0, 1);
        // Halt with a read in flight, drain the buffer, then resume.
        step(0, 1, 0, 0, 0);
        repeat (3) step(0, 1, 0, 0, 0);
        repeat (3) step(0, 1, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        repeat (6) step(0, 0, 0, 0, 1);
        // Redirect while halted, then start from the new address.
        step(0, 1, 0, 0, 1);
        repeat (3) step(0, 1, 0, 0, 1);
        step(0, 0, 1, 5, 1);
        step(1, 0, 0, 0, 1);
        repeat (4) step(0, 0, 0, 0, 1);

        // Randomized control and handshake traffic.
        begin
            bit hr = 1'b0;
            for (int i = 0; i < 3000; i++) begin
                bit st, rv, rdy;
                if ($urandom_range(0, 99) < 4) hr = ~hr;
                st  = ($urandom_range(0, 99) < 6);
                rv  = ($urandom_range(0, 99) < 6);
                rdy = ($urandom_range(0, 99) < 65);
                step(st, hr, rv, int'($urandom_range(0, MEM_SIZE - 1)), rdy);
            end
        end

        // Asynchronous reset between clock edges while streaming.
        step(0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        repeat (4) step(0, 0, 0, 0, 1);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_inst_valid", inst_valid, 1'b0);
        check("async_imem_rd_en", imem_rd_en, 1'b0);
        check("async_busy", busy, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        repeat (3) step(0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        repeat (5) step(0, 0, 0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
